// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
// Module   : dm_responder
// Purpose  : Data-memory responder for the CPU M-stage port. It provides
//            byte-enable merged writes, combinational reads and a
//            first-word-fall-through write-trace FIFO.
//            Optional macro DM_MISALIGN_CHECK_EN rejects misaligned byteen
//            patterns.
// Revision : 1.0 - initial release
// ============================================================================
module dm_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LOG_DEPTH  = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [31:0]                    m_data_addr,
    input  logic [31:0]                    m_data_wdata,
    input  logic [3:0]                     m_data_byteen,
    input  logic [31:0]                    m_inst_addr,
    output logic [31:0]                    m_data_rdata,
    output logic                           log_valid,
    input  logic                           log_ready,
    output logic [31:0]                    log_pc,
    output logic [31:0]                    log_addr,
    output logic [31:0]                    log_data,
    output logic [3:0]                     log_byteen,
    output logic [$clog2(LOG_DEPTH+1)-1:0] log_count,
    output logic                           log_overflow,
    output logic                           addr_err
);
    localparam int C_WORDS = 1 << ADDR_WIDTH;
    localparam int C_PTR_W = $clog2(LOG_DEPTH);
    localparam int C_CNT_W = $clog2(LOG_DEPTH + 1);
    localparam logic [C_CNT_W-1:0] C_FULL = C_CNT_W'(LOG_DEPTH);

    logic [31:0]        mem_q       [C_WORDS];
    logic [31:0]        fifo_pc_q   [LOG_DEPTH];
    logic [31:0]        fifo_addr_q [LOG_DEPTH];
    logic [31:0]        fifo_data_q [LOG_DEPTH];
    logic [3:0]         fifo_be_q   [LOG_DEPTH];

    logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_CNT_W-1:0] count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               addr_err_q, addr_err_d;

    logic                  w_in_range;
    logic [ADDR_WIDTH-1:0] w_index;
    logic [31:0]           w_old_word;
    logic [31:0]           w_mask;
    logic [31:0]           w_new_word;
    logic [31:0]           w_aligned_addr;
    logic                  w_legal;
    logic                  w_write_req;
    logic                  w_commit;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_unused_ok;

    assign w_in_range     = (m_data_addr[31:ADDR_WIDTH+2] == '0);
    assign w_index        = m_data_addr[ADDR_WIDTH+1:2];
    assign w_old_word     = mem_q[w_index];
    assign w_aligned_addr = {m_data_addr[31:2], 2'b00};
    assign w_unused_ok    = &{1'b0, m_data_addr[1:0]};

    for (genvar i = 0; i < 4; i++) begin : g_mask
        assign w_mask[8*i +: 8] = {8{m_data_byteen[i]}};
    end

    assign w_new_word = (w_old_word & ~w_mask) | (m_data_wdata & w_mask);

`ifdef DM_MISALIGN_CHECK_EN
    always_comb begin
        w_legal = 1'b0;
        case (m_data_byteen)
            4'b1111: w_legal = (m_data_addr[1:0] == 2'd0);
            4'b0011: w_legal = (m_data_addr[1:0] == 2'd0);
            4'b1100: w_legal = (m_data_addr[1:0] == 2'd2);
            4'b0001: w_legal = (m_data_addr[1:0] == 2'd0);
            4'b0010: w_legal = (m_data_addr[1:0] == 2'd1);
            4'b0100: w_legal = (m_data_addr[1:0] == 2'd2);
            4'b1000: w_legal = (m_data_addr[1:0] == 2'd3);
            default: w_legal = 1'b0;
        endcase
    end
`else
    assign w_legal = 1'b1;
`endif

    assign w_write_req  = (m_data_byteen != 4'b0000);
    assign w_commit     = w_write_req && w_in_range && w_legal;
    assign m_data_rdata = w_in_range ? w_old_word : 32'h0;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    always_comb begin
        w_pop      = (count_q != '0) && log_ready;
        w_push     = w_commit && ((count_q != C_FULL) || w_pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        addr_err_d = addr_err_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_CNT_W'(1);
            2'b01:   count_d = count_q - C_CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (w_commit && !w_push) begin
            overflow_d = 1'b1;
        end
        if (w_write_req && !w_commit) begin
            addr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < C_WORDS; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            if (w_commit) begin
                mem_q[w_index] <= w_new_word;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Storage needs no reset: outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            fifo_pc_q[wr_ptr_q]   <= m_inst_addr;
            fifo_addr_q[wr_ptr_q] <= w_aligned_addr;
            fifo_data_q[wr_ptr_q] <= w_new_word;
            fifo_be_q[wr_ptr_q]   <= m_data_byteen;
        end
    end

    assign log_valid    = (count_q != '0);
    assign log_pc       = log_valid ? fifo_pc_q[rd_ptr_q]   : 32'h0;
    assign log_addr     = log_valid ? fifo_addr_q[rd_ptr_q] : 32'h0;
    assign log_data     = log_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
    assign log_byteen   = log_valid ? fifo_be_q[rd_ptr_q]   : 4'h0;
    assign log_count    = count_q;
    assign log_overflow = overflow_q;
    assign addr_err     = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_responder
// Purpose  : Self-checking bench for dm_responder; directed scenarios plus
//            randomized traffic against a queue-based memory/trace model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_responder;
    localparam int ADDR_WIDTH = 12;
    localparam int LOG_DEPTH  = 8;
    localparam int CNT_W      = $clog2(LOG_DEPTH + 1);
    localparam int WORDS      = 1 << ADDR_WIDTH;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      m_data_addr, m_data_wdata, m_inst_addr, m_data_rdata;
    logic [3:0]       m_data_byteen;
    logic             log_valid, log_ready;
    logic [31:0]      log_pc, log_addr, log_data;
    logic [3:0]       log_byteen;
    logic [CNT_W-1:0] log_count;
    logic             log_overflow, addr_err;

    always #5 clk = ~clk;

    dm_responder #(.ADDR_WIDTH(ADDR_WIDTH), .LOG_DEPTH(LOG_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr),
        .m_data_rdata(m_data_rdata),
        .log_valid(log_valid), .log_ready(log_ready),
        .log_pc(log_pc), .log_addr(log_addr), .log_data(log_data),
        .log_byteen(log_byteen), .log_count(log_count),
        .log_overflow(log_overflow), .addr_err(addr_err)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } rec_t;

    logic [31:0] mem_m [WORDS];
    rec_t        q_m[$];
    logic        ovf_m, err_m;
    int          n_cmp = 0;
    int          n_fail = 0;

    function automatic bit legal_m(input logic [31:0] a, input logic [3:0] be);
`ifdef DM_MISALIGN_CHECK_EN
        int lane = int'(a[1:0]);
        if (be == 4'b1111) return lane == 0;
        if (be == 4'b0011) return lane == 0;
        if (be == 4'b1100) return lane == 2;
        if ($onehot(be))   return be[lane];
        return 1'b0;
`else
        return (a != 32'hFFFF_FFFF) || (be != 4'hF) || 1'b1;
`endif
    endfunction

    function automatic bit in_range_m(input logic [31:0] a);
        return a < 32'(4 * WORDS);
    endfunction

    function automatic logic [31:0] exp_rdata();
        return in_range_m(m_data_addr) ? mem_m[m_data_addr / 4] : 32'h0;
    endfunction

    function automatic rec_t exp_head();
        return (q_m.size() != 0) ? q_m[0] : rec_t'(0);
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         input logic [31:0] pc, input logic rdy, input logic rst);
        m_data_addr   = a;
        m_data_wdata  = wd;
        m_data_byteen = be;
        m_inst_addr   = pc;
        log_ready     = rdy;
        reset         = rst;
        #1;
    endtask

    // Advance one clock, updating the reference model from the presented inputs.
    task automatic tick();
        logic [31:0] nw;
        bit          commit;
        if (reset) begin
            for (int i = 0; i < WORDS; i++) mem_m[i] = 32'h0;
            q_m.delete();
            ovf_m = 1'b0;
            err_m = 1'b0;
        end else begin
            commit = (m_data_byteen != 0) && in_range_m(m_data_addr) &&
                     legal_m(m_data_addr, m_data_byteen);
            if (q_m.size() != 0 && log_ready) void'(q_m.pop_front());
            if (commit) begin
                nw = mem_m[m_data_addr / 4];
                for (int b = 0; b < 4; b++)
                    if (m_data_byteen[b]) nw[8*b +: 8] = m_data_wdata[8*b +: 8];
                mem_m[m_data_addr / 4] = nw;
                if (q_m.size() < LOG_DEPTH)
                    q_m.push_back('{m_inst_addr, m_data_addr & ~32'h3, nw, m_data_byteen});
                else
                    ovf_m = 1'b1;
            end else if (m_data_byteen != 0) begin
                err_m = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        drive(32'h20, 32'h5555_AAAA, 4'hF, 32'h100, 1'b0, 1'b0);
        tick();
        drive(32'h10, 32'h1234_5678, 4'hF, 32'h104, 1'b0, 1'b1);
        tick();
        drive(32'h20, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (m_data_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_clear_mem: got %h want %h", m_data_rdata, 32'h0);
        end
        drive(32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (m_data_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_write_discard: got %h want %h", m_data_rdata, 32'h0);
        end
        n_cmp++;
        if ({log_valid, log_count, log_overflow, addr_err} !== '0) begin
            n_fail++; $display("FAIL reset_flags: got v=%b c=%0d o=%b e=%b want all 0",
                               log_valid, log_count, log_overflow, addr_err);
        end
        n_cmp++;
        if ({log_pc, log_addr, log_data, log_byteen} !== '0) begin
            n_fail++; $display("FAIL reset_log_fields: got %h %h %h %h want 0",
                               log_pc, log_addr, log_data, log_byteen);
        end
    endtask

    task automatic test_store_word();
        drive(32'h10, 32'hDEAD_BEEF, 4'hF, 32'h3000, 1'b0, 1'b0);
        tick();
        drive(32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (m_data_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL sw_read: got %h want %h", m_data_rdata, 32'hDEAD_BEEF);
        end
        n_cmp++;
        if ({log_valid, log_pc, log_addr, log_data, log_byteen} !==
            {1'b1, 32'h3000, 32'h10, 32'hDEAD_BEEF, 4'hF}) begin
            n_fail++; $display("FAIL sw_log: got v=%b %h %h %h %h want 1 3000 10 deadbeef f",
                               log_valid, log_pc, log_addr, log_data, log_byteen);
        end
    endtask

    task automatic test_partial();
        drive(32'h12, 32'h00AA_0000, 4'b0100, 32'h3004, 1'b1, 1'b0);
        n_cmp++;
        if (m_data_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL sb_same_cycle_read: got %h want %h", m_data_rdata, 32'hDEAD_BEEF);
        end
        tick();
        drive(32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (m_data_rdata !== 32'hDEAA_BEEF) begin
            n_fail++; $display("FAIL sb_merge: got %h want %h", m_data_rdata, 32'hDEAA_BEEF);
        end
        n_cmp++;
        if ({log_count, log_addr, log_data, log_byteen} !==
            {CNT_W'(1), 32'h10, 32'hDEAA_BEEF, 4'b0100}) begin
            n_fail++; $display("FAIL sb_log: got c=%0d %h %h %h want 1 10 deaabeef 4",
                               log_count, log_addr, log_data, log_byteen);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] data [9];
        do_reset();
        for (int k = 0; k < 9; k++) begin
            data[k] = $urandom;
            drive(32'h100 + 32'(4 * k), data[k], 4'hF, 32'h4000 + 32'(4 * k), 1'b0, 1'b0);
            tick();
        end
        drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (log_count !== CNT_W'(8) || log_overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_state: got c=%0d o=%b want 8 1", log_count, log_overflow);
        end
        for (int k = 0; k < 9; k++) begin
            drive(32'h100 + 32'(4 * k), 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
            n_cmp++;
            if (m_data_rdata !== data[k]) begin
                n_fail++; $display("FAIL ovf_mem[%0d]: got %h want %h", k, m_data_rdata, data[k]);
            end
        end
        for (int k = 0; k < 8; k++) begin
            drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
            n_cmp++;
            if ({log_valid, log_pc, log_data} !== {1'b1, 32'h4000 + 32'(4 * k), data[k]}) begin
                n_fail++; $display("FAIL drain[%0d]: got v=%b %h %h want 1 %h %h", k,
                                   log_valid, log_pc, log_data, 32'h4000 + 32'(4 * k), data[k]);
            end
            tick();
        end
        drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        n_cmp++;
        if (log_valid !== 1'b0 || log_count !== '0) begin
            n_fail++; $display("FAIL drain_empty: got v=%b c=%0d want 0 0", log_valid, log_count);
        end
        tick();
        n_cmp++;
        if (log_count !== '0) begin
            n_fail++; $display("FAIL empty_ready: got c=%0d want 0", log_count);
        end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(32'h200 + 32'(4 * k), $urandom, 4'hF, 32'h7000 + 32'(4 * k), 1'b0, 1'b0);
            tick();
        end
        drive(32'h300, 32'h0BAD_F00D, 4'hF, 32'h7100, 1'b1, 1'b0);
        tick();
        drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if ({log_count, log_overflow, log_pc} !== {CNT_W'(8), 1'b0, 32'h7004}) begin
            n_fail++; $display("FAIL full_pushpop: got c=%0d o=%b pc=%h want 8 0 7004",
                               log_count, log_overflow, log_pc);
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        drive(32'h0001_0000, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (addr_err !== 1'b0) begin
            n_fail++; $display("FAIL oor_read_err: got %b want 0", addr_err);
        end
        drive(32'h0001_0000, 32'hCAFE_F00D, 4'hF, 32'h5000, 1'b0, 1'b0);
        n_cmp++;
        if (m_data_rdata !== 32'h0) begin
            n_fail++; $display("FAIL oor_rdata: got %h want 0", m_data_rdata);
        end
        tick();
        drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if ({addr_err, log_valid, log_count, m_data_rdata} !== {1'b1, 1'b0, CNT_W'(0), 32'h0}) begin
            n_fail++; $display("FAIL oor_write: got e=%b v=%b c=%0d word0=%h want 1 0 0 0",
                               addr_err, log_valid, log_count, m_data_rdata);
        end
    endtask

    task automatic test_misalign();
        do_reset();
        drive(32'h11, 32'h1122_3344, 4'hF, 32'h6000, 1'b0, 1'b0);
        tick();
        drive(32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
`ifdef DM_MISALIGN_CHECK_EN
        n_cmp++;
        if ({addr_err, log_count, m_data_rdata} !== {1'b1, CNT_W'(0), 32'h0}) begin
            n_fail++; $display("FAIL misalign: got e=%b c=%0d w=%h want 1 0 0",
                               addr_err, log_count, m_data_rdata);
        end
`else
        n_cmp++;
        if ({addr_err, log_count, m_data_rdata} !== {1'b0, CNT_W'(1), 32'h1122_3344}) begin
            n_fail++; $display("FAIL misalign: got e=%b c=%0d w=%h want 0 1 11223344",
                               addr_err, log_count, m_data_rdata);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [3:0]  be;
        logic        rdy;
        rec_t        h;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) a = $urandom | 32'h0000_4000;
            else                            a = 32'($urandom_range(0, 63));
            be  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            rdy = $urandom_range(0, 99) < (((i / 60) % 2 == 1) ? 85 : 15);
            drive(a, $urandom, be, $urandom, rdy, (i == 300));
            h = exp_head();
            n_cmp++;
            if (m_data_rdata !== exp_rdata()) begin
                n_fail++; $display("FAIL rnd_rdata @%0d: got %h want %h", i, m_data_rdata, exp_rdata());
            end
            n_cmp++;
            if (log_valid !== (q_m.size() != 0) || log_count !== CNT_W'(q_m.size())) begin
                n_fail++; $display("FAIL rnd_count @%0d: got v=%b c=%0d want c=%0d",
                                   i, log_valid, log_count, q_m.size());
            end
            n_cmp++;
            if ({log_pc, log_addr, log_data, log_byteen} !== h) begin
                n_fail++; $display("FAIL rnd_head @%0d: got %h %h %h %h want %h %h %h %h", i,
                                   log_pc, log_addr, log_data, log_byteen, h.pc, h.addr, h.data, h.be);
            end
            n_cmp++;
            if (log_overflow !== ovf_m || addr_err !== err_m) begin
                n_fail++; $display("FAIL rnd_flags @%0d: got o=%b e=%b want o=%b e=%b",
                                   i, log_overflow, addr_err, ovf_m, err_m);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_partial();
        test_overflow();
        test_full_pushpop();
        test_out_of_range();
        test_misalign();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
